// File: rtl/uart_reg_cmd.sv
// ASCII peek/poke command interpreter: parses hex W/R commands from the UART RX FIFO,
// drives a single-cycle register bus and pushes ASCII replies into the UART TX FIFO.
module uart_reg_cmd #(
    parameter int unsigned ADDR_HEX = 2,
    parameter int unsigned DATA_HEX = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  rx_empty_i,
    input  logic [7:0]            r_data_i,
    output logic                  rd_uart_o,
    input  logic                  tx_full_i,
    output logic [7:0]            w_data_o,
    output logic                  wr_uart_o,
    output logic [4*ADDR_HEX-1:0] reg_addr_o,
    output logic [4*DATA_HEX-1:0] reg_wdata_o,
    output logic                  reg_we_o,
    output logic                  reg_re_o,
    input  logic [4*DATA_HEX-1:0] reg_rdata_i,
    output logic                  busy_o
);

    localparam int unsigned AW   = 4 * ADDR_HEX;
    localparam int unsigned DW   = 4 * DATA_HEX;
    localparam int unsigned NBUF = DATA_HEX + 2;
    localparam int unsigned IW   = $clog2(NBUF);
    localparam int unsigned MAXH = (ADDR_HEX > DATA_HEX) ? ADDR_HEX : DATA_HEX;
    localparam int unsigned CW   = $clog2(MAXH + 1);

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_Q  = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_EOL, S_FLUSH, S_EXEC, S_RDWAIT, S_SEND
    } state_e;

    state_e          state_q, state_d;
    logic            op_wr_q, op_wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            re_q, re_d;
    logic [7:0]      rbuf_q [NBUF];
    logic [7:0]      rbuf_d [NBUF];
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_last_c;
    logic            err_c;

    function automatic logic is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    // Valid only for hex characters; letters share the low nibble pattern 1..6.
    function automatic logic [3:0] hex_val(input logic [7:0] c);
        return (c <= 8'h39) ? c[3:0] : 4'(c[3:0] + 4'd9);
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'(8'h30 + {4'h0, n}) : 8'(8'h37 + {4'h0, n});
    endfunction

    assign cnt_last_c = (state_q == S_ADDR) ? CW'(ADDR_HEX - 1) : CW'(DATA_HEX - 1);

    // Next-state, RX pop and TX push decode
    always_comb begin
        state_d   = state_q;
        op_wr_d   = op_wr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        rbuf_d    = rbuf_q;
        idx_d     = idx_q;
        last_d    = last_q;
        err_c     = 1'b0;
        rd_uart_o = 1'b0;
        wr_uart_o = 1'b0;
        w_data_o  = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (!rx_empty_i) begin
                    rd_uart_o = 1'b1;
                    cnt_d     = '0;
                    if (r_data_i == 8'h57 || r_data_i == 8'h77) begin
                        op_wr_d = 1'b1;
                        state_d = S_ADDR;
                    end else if (r_data_i == 8'h52 || r_data_i == 8'h72) begin
                        op_wr_d = 1'b0;
                        state_d = S_ADDR;
                    end else if (r_data_i != CH_CR && r_data_i != CH_LF) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                if (!rx_empty_i) begin
                    rd_uart_o = 1'b1;
                    if (is_hex(r_data_i)) begin
                        if (state_q == S_ADDR) begin
                            addr_d = (addr_q << 4) | AW'(hex_val(r_data_i));
                        end else begin
                            wdata_d = (wdata_q << 4) | DW'(hex_val(r_data_i));
                        end
                        if (cnt_q == cnt_last_c) begin
                            cnt_d   = '0;
                            state_d = (state_q == S_ADDR && op_wr_q) ? S_DATA : S_EOL;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (r_data_i == CH_CR) begin
                        err_c = 1'b1;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_EOL: begin
                if (!rx_empty_i) begin
                    rd_uart_o = 1'b1;
                    if (r_data_i == CH_CR) begin
                        we_d    = op_wr_q;
                        re_d    = !op_wr_q;
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (!rx_empty_i) begin
                    rd_uart_o = 1'b1;
                    err_c     = (r_data_i == CH_CR);
                end
            end
            S_EXEC: begin
                if (op_wr_q) begin
                    rbuf_d[0] = CH_K;
                    rbuf_d[1] = CH_CR;
                    rbuf_d[2] = CH_LF;
                    last_d    = IW'(2);
                    idx_d     = '0;
                    state_d   = S_SEND;
                end else begin
                    state_d = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                for (int unsigned i = 0; i < DATA_HEX; i++) begin
                    rbuf_d[i] = hex_char(4'(reg_rdata_i >> (4 * (DATA_HEX - 1 - i))));
                end
                rbuf_d[DATA_HEX]     = CH_CR;
                rbuf_d[DATA_HEX + 1] = CH_LF;
                last_d  = IW'(NBUF - 1);
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (!tx_full_i) begin
                    wr_uart_o = 1'b1;
                    w_data_o  = rbuf_q[idx_q];
                    if (idx_q == last_q) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A CR that terminates a malformed command queues the error reply immediately.
        if (err_c) begin
            rbuf_d[0] = CH_Q;
            rbuf_d[1] = CH_CR;
            rbuf_d[2] = CH_LF;
            last_d    = IW'(2);
            idx_d     = '0;
            state_d   = S_SEND;
        end

        if (reset_i) begin
            rd_uart_o = 1'b0;
            wr_uart_o = 1'b0;
            w_data_o  = 8'h00;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            op_wr_q <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            rbuf_q  <= '{default: 8'h00};
            idx_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            rbuf_q  <= rbuf_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_we_o    = we_q;
    assign reg_re_o    = re_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_reg_cmd.sv
// Randomized scoreboard bench for uart_reg_cmd: FIFO/register-slave models plus a
// line-level command reference model that predicts bus cycles and ASCII replies.
module tb_uart_reg_cmd;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       tx_full = 1'b0;
    logic [7:0] reg_rdata = 8'h00;
    logic       rd_uart, wr_uart, reg_we, reg_re, busy;
    logic [7:0] w_data, reg_addr, reg_wdata;

    uart_reg_cmd #(.ADDR_HEX(2), .DATA_HEX(2)) dut (
        .clk_i(clk), .reset_i(reset), .rx_empty_i(rx_empty), .r_data_i(r_data),
        .rd_uart_o(rd_uart), .tx_full_i(tx_full), .w_data_o(w_data), .wr_uart_o(wr_uart),
        .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata), .reg_we_o(reg_we), .reg_re_o(reg_re),
        .reg_rdata_i(reg_rdata), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0]  rx_q[$], rx_in[$], exp_tx[$], exp_re[$];
    logic [15:0] exp_we[$];
    logic [7:0]  slv_mem[256];
    logic [7:0]  model_mem[256];
    string       hex_up = "0123456789ABCDEF";
    string       hex_lo = "0123456789abcdef";

    bit         pop_flag = 0, re_flag = 0, force_full = 0, rand_full = 0, lat_chk = 0;
    bit         at_start = 1, prev_lf = 0;
    logic [7:0] re_addr = 8'h00;
    logic [7:0] e8;
    logic [15:0] e16;
    int         cyc = 0, last_cr = 0, last_we = 0, last_re = 0, tx_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RX FIFO, TX backpressure and register read-data driver, updated just after the edge
    always @(posedge clk) begin
        #1;
        if (pop_flag && rx_q.size() > 0) rx_q.delete(0);
        while (rx_in.size() > 0) rx_q.push_back(rx_in.pop_front());
        rx_empty  = (rx_q.size() == 0);
        r_data    = rx_empty ? 8'h00 : rx_q[0];
        tx_full   = force_full || (rand_full && ($urandom_range(0, 2) == 0));
        reg_rdata = re_flag ? slv_mem[re_addr] : 8'($urandom);
    end

    // Monitor: compares every DUT transaction against the scoreboard queues
    always @(negedge clk) begin
        cyc++;
        pop_flag = rd_uart;
        re_flag  = reg_re;
        re_addr  = reg_addr;
        if (reset) begin
            at_start = 1;
            prev_lf  = 0;
        end else begin
            if (prev_lf) check("busy_after_lf", 32'(busy), 0);
            prev_lf = 0;
            if (rd_uart) begin
                check("pop_when_empty", 32'(rx_empty), 0);
                if (r_data == 8'h0D) last_cr = cyc;
            end
            if (wr_uart) begin
                check("wr_while_full", 32'(tx_full), 0);
                tx_count++;
                check("tx_expected_pending", 32'(exp_tx.size() != 0), 1);
                if (exp_tx.size() != 0) begin
                    e8 = exp_tx.pop_front();
                    if (lat_chk && at_start) begin
                        if (e8 == 8'h4B)      check("k_latency", 32'(cyc - last_we), 1);
                        else if (e8 == 8'h3F) check("err_latency", 32'(cyc - last_cr), 1);
                        else                  check("rd_latency", 32'(cyc - last_re), 2);
                    end
                    check("tx_byte", 32'(w_data), 32'(e8));
                    at_start = (e8 == 8'h0A);
                    prev_lf  = (e8 == 8'h0A);
                end
            end
            if (reg_we) begin
                last_we = cyc;
                check("we_after_cr", 32'(cyc - last_cr), 1);
                check("we_expected_pending", 32'(exp_we.size() != 0), 1);
                if (exp_we.size() != 0) begin
                    e16 = exp_we.pop_front();
                    check("we_addr_data", 32'({reg_addr, reg_wdata}), 32'(e16));
                end
                slv_mem[reg_addr] = reg_wdata;
            end
            if (reg_re) begin
                last_re = cyc;
                check("re_after_cr", 32'(cyc - last_cr), 1);
                check("re_expected_pending", 32'(exp_re.size() != 0), 1);
                if (exp_re.size() != 0) begin
                    e8 = exp_re.pop_front();
                    check("re_addr", 32'(reg_addr), 32'(e8));
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic string cmd(input string body);
        return $sformatf("%s%c", body, 8'h0D);
    endfunction

    function automatic bit all_hex(input string s, input int a, input int b);
        logic [7:0] ch;
        for (int i = a; i <= b; i++) begin
            ch = s[i];
            if (!((ch >= "0" && ch <= "9") || (ch >= "A" && ch <= "F") || (ch >= "a" && ch <= "f")))
                return 0;
        end
        return 1;
    endfunction

    task automatic push_reply(input string t);
        for (int i = 0; i < t.len(); i++) exp_tx.push_back(t[i]);
        exp_tx.push_back(8'h0D);
        exp_tx.push_back(8'h0A);
    endtask

    // Reference model for one CR-terminated line (CR already stripped)
    task automatic model_line(input string l);
        int k = 0;
        int a, d;
        logic [7:0] c, v;
        while (k < l.len() && l[k] == 8'h0A) k++;
        if (k >= l.len()) return;
        l = l.substr(k, l.len() - 1);
        c = l[0];
        if ((c == "W" || c == "w") && l.len() == 5 && all_hex(l, 1, 4)) begin
            a = l.substr(1, 2).atohex();
            d = l.substr(3, 4).atohex();
            exp_we.push_back({8'(a), 8'(d)});
            model_mem[8'(a)] = 8'(d);
            push_reply("K");
        end else if ((c == "R" || c == "r") && l.len() == 3 && all_hex(l, 1, 2)) begin
            a = l.substr(1, 2).atohex();
            v = model_mem[8'(a)];
            exp_re.push_back(8'(a));
            push_reply($sformatf("%c%c", hex_up[int'(v[7:4])], hex_up[int'(v[3:0])]));
        end else begin
            push_reply("?");
        end
    endtask

    task automatic feed(input string s);
        string cur = "";
        for (int i = 0; i < s.len(); i++) begin
            rx_in.push_back(s[i]);
            if (s[i] == 8'h0D) begin
                model_line(cur);
                cur = "";
            end else begin
                cur = $sformatf("%s%c", cur, s[i]);
            end
        end
    endtask

    task automatic feed_raw(input string s);
        for (int i = 0; i < s.len(); i++) rx_in.push_back(s[i]);
    endtask

    function automatic string rhex(input int n);
        string s = "";
        int v;
        for (int i = 0; i < n; i++) begin
            v = int'($urandom_range(0, 15));
            s = $sformatf("%s%c", s, ($urandom_range(0, 1) == 1) ? hex_up[v] : hex_lo[v]);
        end
        return s;
    endfunction

    task automatic rand_line(output string s);
        int kind = int'($urandom_range(0, 6));
        int p;
        string pre, post;
        logic [7:0] ch;
        case (kind)
            0, 1: s = {($urandom_range(0, 1) == 1) ? "W" : "w", rhex(2), rhex(2)};
            2, 3: s = {($urandom_range(0, 1) == 1) ? "R" : "r", rhex(2)};
            4:    s = $sformatf("%c%cR%s", 8'h0A, 8'h0D, rhex(2));
            5: begin
                s   = {"W", rhex(2), rhex(2)};
                p   = int'($urandom_range(0, 4));
                ch  = 8'($urandom_range(8'h21, 8'h7E));
                pre = (p > 0) ? s.substr(0, p - 1) : "";
                post = (p < 4) ? s.substr(p + 1, 4) : "";
                s   = $sformatf("%s%c%s", pre, ch, post);
            end
            default: s = {"w", rhex(2), rhex(1)};
        endcase
        s = cmd(s);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (!(rx_in.size() == 0 && rx_q.size() == 0 && exp_tx.size() == 0 &&
                 exp_we.size() == 0 && exp_re.size() == 0 && busy == 1'b0) && n < budget) begin
            cycles(1);
            n++;
        end
        check({"drain_", name}, 32'(n < budget), 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rd_uart"}, 32'(rd_uart), 0);
        check({tag, "_wr_uart"}, 32'(wr_uart), 0);
        check({tag, "_reg_we"}, 32'(reg_we), 0);
        check({tag, "_reg_re"}, 32'(reg_re), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_w_data"}, 32'(w_data), 0);
        check({tag, "_reg_addr"}, 32'(reg_addr), 0);
        check({tag, "_reg_wdata"}, 32'(reg_wdata), 0);
    endtask

    initial begin
        string s;
        int n0, n;
        for (int i = 0; i < 256; i++) begin
            slv_mem[i]   = 8'($urandom);
            model_mem[i] = slv_mem[i];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk);
        #2 reset = 1'b0;
        lat_chk = 1;

        slv_mem[8'h3C]   = 8'h5B;
        model_mem[8'h3C] = 8'h5B;
        feed(cmd("r3c"));
        drain("read_3c", 200);
        feed(cmd("W3CA5"));
        drain("write_3c", 200);
        check("mem_3c_written", 32'(slv_mem[8'h3C]), 32'h00A5);
        feed(cmd("W3GA5"));
        feed(cmd("R00"));
        drain("bad_digit", 300);
        feed($sformatf("%c%c%c%cR01%c", 8'h0D, 8'h0A, 8'h0D, 8'h0A, 8'h0D));
        drain("noise", 300);

        // Backpressure across a whole read reply
        lat_chk    = 0;
        force_full = 1;
        feed(cmd("R05"));
        n0 = tx_count;
        cycles(20);
        check("bp_no_tx", 32'(tx_count - n0), 0);
        check("bp_busy", 32'(busy), 1);
        force_full = 0;
        drain("backpressure", 200);
        check("bp_tx_count", 32'(tx_count - n0), 4);

        // Reset with a partial command already consumed
        lat_chk = 1;
        feed_raw("W1");
        n = 0;
        while ((rx_in.size() != 0 || rx_q.size() != 0) && n < 200) begin
            cycles(1);
            n++;
        end
        check("w1_popped", 32'(n < 200), 1);
        cycles(1);
        reset = 1'b1;
        feed(cmd("W1234"));
        @(posedge clk);
        @(negedge clk);
        check_reset("mid");
        cycles(1);
        reset = 1'b0;
        drain("after_reset", 300);
        check("mem_12_written", 32'(slv_mem[8'h12]), 32'h0034);

        // Randomized command stream with random TX backpressure
        lat_chk   = 0;
        rand_full = 1;
        repeat (80) begin
            rand_line(s);
            feed(s);
            cycles(int'($urandom_range(0, 6)));
        end
        drain("random", 20000);
        rand_full = 0;

        check("tx_left", 32'(exp_tx.size()), 0);
        check("we_left", 32'(exp_we.size()), 0);
        check("re_left", 32'(exp_re.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_reg_cmd.md
# uart_reg_cmd

ASCII command interpreter that sits directly downstream of the UART block. It pops received bytes from the UART RX FIFO, parses hex write and read commands, and drives a simple single-cycle register bus. It then pushes ASCII replies into the UART TX FIFO. This gives a host terminal peek/poke access to on-chip registers at the UART baud rate.

## Interface
- ADDR_HEX, 2, number of hex digits in an address; address width AW = 4*ADDR_HEX
- DATA_HEX, 2, number of hex digits in data; data width DW = 4*DATA_HEX
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- rx_empty  in  1  UART RX FIFO empty
- r_data  in  8  UART RX FIFO head byte; valid whenever rx_empty=0
- rd_uart  out  1  pop RX FIFO head this cycle
- tx_full  in  1  UART TX FIFO full
- w_data  out  8  byte to push into the TX FIFO
- wr_uart  out  1  push w_data this cycle
- reg_addr  out  AW  register address; holds last parsed value
- reg_wdata  out  DW  register write data; holds last parsed value
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  DW  read data; valid the cycle after reg_re
- busy  out  1  high whenever state is not IDLE

## Operation
- Command grammar: write is 'W'/'w', then ADDR_HEX digits, then DATA_HEX digits, then CR (0x0D). Read is 'R'/'r', then ADDR_HEX digits, then CR.
- Hex digits are 0-9, A-F, a-f. Digits are MSB first and are shifted into reg_addr / reg_wdata.
- Replies:
  - write: "K\r\n"
  - read: DATA_HEX uppercase hex digits, MSB first, then "\r\n"
  - error: "?\r\n"
- States and transitions:
  - IDLE:
    - 'W'/'w' → ADDR with op=write; 'R'/'r' → ADDR with op=read.
    - CR and LF are popped and ignored; the state stays IDLE.
    - Any other byte → FLUSH.
  - ADDR: collect ADDR_HEX digits. When complete, go to DATA if op=write, else EOL.
  - DATA: collect DATA_HEX digits, then go to EOL.
  - EOL: CR → EXEC.
  - Errors in ADDR, DATA or EOL:
    - A non-hex byte, or a non-CR byte in EOL, goes to FLUSH.
    - If the offending byte is itself CR, go straight to SEND with the error reply.
  - FLUSH: pop and discard bytes until a CR is popped, then go to SEND with the error reply.
  - EXEC: assert reg_we (write) or reg_re (read) for exactly one cycle. Write loads the "K\r\n" reply and goes to SEND. Read goes to RDWAIT.
  - RDWAIT: capture reg_rdata, convert it to ASCII hex plus "\r\n" in the reply buffer, go to SEND.
  - SEND: emit reply bytes in order, then return to IDLE.
- The reply buffer holds up to DATA_HEX+2 bytes, with a byte index and a length counter.
- Bytes arriving during EXEC, RDWAIT or SEND stay in the RX FIFO; they are not popped.
- reg_addr and reg_wdata are updated only while digits are being parsed. They hold through EXEC and afterwards.

## Timing
- rd_uart is asserted in IDLE, ADDR, DATA, EOL and FLUSH, only when rx_empty=0.
  - At most one byte is popped per cycle.
  - The byte is decoded in the same cycle it is popped.
  - Back-to-back bytes are accepted at 1 per cycle.
- wr_uart is asserted in SEND only when tx_full=0. It is never asserted while tx_full=1.
  - w_data is valid in the same cycle as wr_uart.
  - The byte index advances only on a cycle where wr_uart=1.
  - tx_full stalls SEND indefinitely, with no byte lost or duplicated.
- Write latency (CR popped in cycle N, TX never full):
  - reg_we in N+1.
  - 'K' in N+2, CR in N+3, LF in N+4.
  - busy falls in N+5.
- Read latency (CR popped in cycle N):
  - reg_re in N+1.
  - reg_rdata sampled at the end of N+2.
  - First hex digit in N+3.
- Error reply: the first '?' appears the cycle after the terminating CR is popped.
- Reset values, with reset asserted on any cycle including mid-command or mid-reply:
  - state=IDLE; rd_uart, wr_uart, reg_we, reg_re and busy are 0.
  - w_data=0, reg_addr=0, reg_wdata=0.
  - The partial command and partial reply are discarded.
  - FIFO contents belong to the UART and are not touched.

## Test plan
- Write "W3CA5\r":
  - reg_we high for exactly 1 cycle with reg_addr=0x3C and reg_wdata=0xA5.
  - TX receives 0x4B,0x0D,0x0A.
- Read "r3c\r" with reg_rdata=0x5B:
  - reg_re high for 1 cycle with reg_addr=0x3C.
  - TX receives "5B\r\n" (0x35,0x42,0x0D,0x0A).
- Bad digit "W3GA5\r":
  - No reg_we, FLUSH discards "A5".
  - TX receives "?\r\n" once. A following "R00\r" then works normally.
- Terminal noise: "\r\n\r\nR01\r" gives exactly one reg_re and one 4-byte reply, with no error reply.
- Backpressure: hold tx_full=1 for 20 cycles during a read reply.
  - wr_uart stays 0 throughout.
  - After release, all 4 bytes arrive in order without duplication, and busy falls afterward.
- Reset after "W1" has been popped:
  - All outputs are at reset values the next cycle.
  - A subsequent "W1234\r" writes reg_addr=0x12 and reg_wdata=0x34 with a clean "K\r\n".
